// File: rtl/sram_arbiter_2p_pkg.sv
// Shared types and constants for the two-port SRAM arbiter/sequencer.
package sram_arb_pkg;

  // Access sequencer states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } state_t;

  // Grant encoding shared by the arbiter and the sequencer.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Width of the wait down-counter: must hold max(rd_wait, wr_wait) - 1.
  function automatic int cnt_width(input int rd_wait, input int wr_wait);
    int max_load;
    max_load = ((rd_wait > wr_wait) ? rd_wait : wr_wait) - 1;
    return (max_load < 2) ? 1 : $clog2(max_load + 1);
  endfunction

endpackage

// File: rtl/sram_arbiter_2p_rr_arb2.sv
// Two-way round-robin grant. A lone requester always wins; on contention the
// port that did not win most recently wins. last_grant moves on every grant
// taken while i_update is high.
module sram_rr_arb2
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_update,
  output logic o_valid,
  output logic o_grant
);

  logic r_last_grant;

  // Combinational grant decision from the current requests and last winner.
  always_comb begin
    o_valid = i_req_a | i_req_b;
    o_grant = PORT_A;
    if (i_req_a && i_req_b) begin
      o_grant = (r_last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (i_req_b) begin
      o_grant = PORT_B;
    end
  end

  // Remember the winner so the next contention goes the other way.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= PORT_B;
    end else if (i_update && o_valid) begin
      r_last_grant <= o_grant;
    end
  end

endmodule

// File: rtl/sram_arbiter_2p.sv
// Two-port arbiter and access sequencer for the external asynchronous SRAM.
// One access at a time; all pin-facing outputs are registered.
module sram_arbiter_2p
  import sram_arb_pkg::*;
#(
  parameter int AW      = 21,
  parameter int DW      = 8,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dout,
  output logic          sram_doe,
  input  logic [DW-1:0] sram_din,
  output logic          sram_we_n,
  output logic          sram_oe_n
);

  localparam int            CW      = cnt_width(RD_WAIT, WR_WAIT);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT - 1);

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_port, w_port_next;
  logic [AW-1:0] r_addr, w_addr_next;
  logic [DW-1:0] r_dout, w_dout_next;
  logic          r_doe, w_doe_next;
  logic          r_we_n, w_we_n_next;
  logic          r_oe_n, w_oe_n_next;
  logic          r_a_ack, w_a_ack_next, r_b_ack, w_b_ack_next;
  logic          r_a_rvalid, w_a_rvalid_next, r_b_rvalid, w_b_rvalid_next;
  logic [DW-1:0] r_a_rdata, w_a_rdata_next, r_b_rdata, w_b_rdata_next;

  logic          w_idle, w_gnt_valid, w_gnt;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  // Requests only compete while idle; busy-time requests simply wait.
  assign w_idle      = (r_state == IDLE);
  assign w_sel_we    = (w_gnt == PORT_B) ? b_we    : a_we;
  assign w_sel_addr  = (w_gnt == PORT_B) ? b_addr  : a_addr;
  assign w_sel_wdata = (w_gnt == PORT_B) ? b_wdata : a_wdata;

  sram_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req_a  (a_req & w_idle),
    .i_req_b  (b_req & w_idle),
    .i_update (w_idle),
    .o_valid  (w_gnt_valid),
    .o_grant  (w_gnt)
  );

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_port_next     = r_port;
    w_addr_next     = r_addr;
    w_dout_next     = r_dout;
    w_doe_next      = r_doe;
    w_we_n_next     = r_we_n;
    w_oe_n_next     = r_oe_n;
    w_a_ack_next    = 1'b0;
    w_b_ack_next    = 1'b0;
    w_a_rvalid_next = 1'b0;
    w_b_rvalid_next = 1'b0;
    w_a_rdata_next  = r_a_rdata;
    w_b_rdata_next  = r_b_rdata;
    case (r_state)
      IDLE: begin
        w_doe_next  = 1'b0;
        w_we_n_next = 1'b1;
        w_oe_n_next = 1'b0;
        if (w_gnt_valid) begin
          w_port_next  = w_gnt;
          w_addr_next  = w_sel_addr;
          w_a_ack_next = (w_gnt == PORT_A);
          w_b_ack_next = (w_gnt == PORT_B);
          if (w_sel_we) begin
            // Turn the bus around first: SRAM outputs off before we drive.
            w_state_next = WR_SETUP;
            w_oe_n_next  = 1'b1;
            w_doe_next   = 1'b1;
            w_dout_next  = w_sel_wdata;
          end else begin
            w_state_next = RD;
            w_cnt_next   = RD_LOAD;
          end
        end
      end
      RD: begin
        if (r_cnt == '0) begin
          w_state_next = IDLE;
          if (r_port == PORT_A) begin
            w_a_rdata_next  = sram_din;
            w_a_rvalid_next = 1'b1;
          end else begin
            w_b_rdata_next  = sram_din;
            w_b_rvalid_next = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      WR_SETUP: begin
        w_state_next = WR_PULSE;
        w_we_n_next  = 1'b0;
        w_cnt_next   = WR_LOAD;
      end
      WR_PULSE: begin
        if (r_cnt == '0) begin
          w_state_next = WR_HOLD;
          w_we_n_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      WR_HOLD: begin
        // Address and data held one cycle past the rising WE_n edge.
        w_state_next = IDLE;
        w_doe_next   = 1'b0;
        w_oe_n_next  = 1'b0;
      end
      default: begin
        w_state_next = IDLE;
        w_doe_next   = 1'b0;
        w_we_n_next  = 1'b1;
      end
    endcase
  end

  // State and registered pin/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_port     <= PORT_B;
      r_addr     <= '0;
      r_dout     <= '0;
      r_doe      <= 1'b0;
      r_we_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_port     <= w_port_next;
      r_addr     <= w_addr_next;
      r_dout     <= w_dout_next;
      r_doe      <= w_doe_next;
      r_we_n     <= w_we_n_next;
      r_oe_n     <= w_oe_n_next;
      r_a_ack    <= w_a_ack_next;
      r_b_ack    <= w_b_ack_next;
      r_a_rvalid <= w_a_rvalid_next;
      r_b_rvalid <= w_b_rvalid_next;
      r_a_rdata  <= w_a_rdata_next;
      r_b_rdata  <= w_b_rdata_next;
    end
  end

  assign sram_addr = r_addr;
  assign sram_dout = r_dout;
  assign sram_doe  = r_doe;
  assign sram_we_n = r_we_n;
  assign sram_oe_n = r_oe_n;
  assign a_ack     = r_a_ack;
  assign b_ack     = r_b_ack;
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Bench for sram_arbiter_2p: instance 0 uses RD_WAIT=WR_WAIT=2, instance 1
// uses RD_WAIT=WR_WAIT=1. Each instance has its own behavioural SRAM.
module tb_sram_arbiter_2p;

  localparam int AW = 21;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req [2], a_we [2], b_req [2], b_we [2];
  logic [AW-1:0] a_addr [2], b_addr [2], sram_addr [2];
  logic [DW-1:0] a_wdata [2], b_wdata [2], a_rdata [2], b_rdata [2];
  logic [DW-1:0] sram_dout [2], sram_din [2];
  logic          a_ack [2], b_ack [2], a_rvalid [2], b_rvalid [2];
  logic          sram_doe [2], sram_we_n [2], sram_oe_n [2];

  logic [7:0]    mem0 [0:(1<<AW)-1];
  logic [7:0]    mem1 [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;

  int n_vec = 0;
  int n_err = 0;
  logic          prev_we_n [2];
  logic [AW-1:0] prev_addr [2];
  logic [DW-1:0] prev_dout [2];

  always #5 clk = ~clk;

  sram_arbiter_2p #(.AW(AW), .DW(DW), .RD_WAIT(2), .WR_WAIT(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
    .a_ack(a_ack[0]), .a_rdata(a_rdata[0]), .a_rvalid(a_rvalid[0]),
    .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
    .b_ack(b_ack[0]), .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]),
    .sram_addr(sram_addr[0]), .sram_dout(sram_dout[0]), .sram_doe(sram_doe[0]),
    .sram_din(sram_din[0]), .sram_we_n(sram_we_n[0]), .sram_oe_n(sram_oe_n[0])
  );

  sram_arbiter_2p #(.AW(AW), .DW(DW), .RD_WAIT(1), .WR_WAIT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
    .a_ack(a_ack[1]), .a_rdata(a_rdata[1]), .a_rvalid(a_rvalid[1]),
    .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
    .b_ack(b_ack[1]), .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]),
    .sram_addr(sram_addr[1]), .sram_dout(sram_dout[1]), .sram_doe(sram_doe[1]),
    .sram_din(sram_din[1]), .sram_we_n(sram_we_n[1]), .sram_oe_n(sram_oe_n[1])
  );

  // SRAM models: asynchronous read, write while WE_n is low, plus a preload path.
  assign sram_din[0] = mem0[sram_addr[0]];
  assign sram_din[1] = mem1[sram_addr[1]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem0[pl_addr] <= pl_data;
      mem1[pl_addr] <= pl_data;
    end
    if (!sram_we_n[0]) mem0[sram_addr[0]] <= sram_dout[0];
    if (!sram_we_n[1]) mem1[sram_addr[1]] <= sram_dout[1];
  end

  function automatic int rdw(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int wrw(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end else begin
      $display("ok   %s dut%0d: %0h", name, d, act);
    end
  endtask

  // Advance one clock and sample at the falling edge; bus invariants checked every cycle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (sram_doe[d] && !sram_oe_n[d]) chk("doe_with_oe", d, 32'd1, 32'd0);
      if (!prev_we_n[d] && !sram_we_n[d]) begin
        chk("addr_stable_we", d, 32'(sram_addr[d]), 32'(prev_addr[d]));
        chk("dout_stable_we", d, 32'(sram_dout[d]), 32'(prev_dout[d]));
      end
      prev_we_n[d] = sram_we_n[d];
      prev_addr[d] = sram_addr[d];
      prev_dout[d] = sram_dout[d];
    end
  endtask

  task automatic set_req(input int d, input bit p, input logic r, input logic we,
                         input logic [AW-1:0] ad, input logic [DW-1:0] dat);
    if (p) begin
      b_req[d] = r; b_we[d] = we; b_addr[d] = ad; b_wdata[d] = dat;
    end else begin
      a_req[d] = r; a_we[d] = we; a_addr[d] = ad; a_wdata[d] = dat;
    end
  endtask

  function automatic logic ack_of(input int d, input bit p);
    return p ? b_ack[d] : a_ack[d];
  endfunction

  function automatic logic rv_of(input int d, input bit p);
    return p ? b_rvalid[d] : a_rvalid[d];
  endfunction

  function automatic logic [7:0] mem_of(input int d, input logic [AW-1:0] ad);
    return (d == 0) ? mem0[ad] : mem1[ad];
  endfunction

  // One access from an idle DUT, checked cycle by cycle against the expected waveform.
  task automatic do_txn(input int d, input bit p, input bit we, input logic [AW-1:0] ad, input logic [7:0] dat);
    set_req(d, p, 1'b1, we, ad, dat);
    step();
    chk("ack", d, 32'(ack_of(d, p)), 32'd1);
    chk("other_ack", d, 32'(ack_of(d, ~p)), 32'd0);
    chk("addr", d, 32'(sram_addr[d]), 32'(ad));
    set_req(d, p, 1'b0, 1'b0, '0, '0);
    if (!we) begin
      chk("rd_oe_n", d, 32'(sram_oe_n[d]), 32'd0);
      chk("rd_doe", d, 32'(sram_doe[d]), 32'd0);
      for (int i = 1; i < rdw(d); i++) begin
        step();
        chk("rd_early_rvalid", d, 32'(rv_of(d, p)), 32'd0);
        chk("rd_ack_pulse", d, 32'(ack_of(d, p)), 32'd0);
      end
      step();
      chk("rvalid", d, 32'(rv_of(d, p)), 32'd1);
      chk("other_rvalid", d, 32'(rv_of(d, ~p)), 32'd0);
      chk("rdata", d, 32'(p ? b_rdata[d] : a_rdata[d]), 32'(dat));
    end else begin
      chk("wr_setup_we_n", d, 32'(sram_we_n[d]), 32'd1);
      chk("wr_setup_doe", d, 32'(sram_doe[d]), 32'd1);
      chk("wr_setup_oe_n", d, 32'(sram_oe_n[d]), 32'd1);
      chk("wr_setup_dout", d, 32'(sram_dout[d]), 32'(dat));
      for (int i = 0; i < wrw(d); i++) begin
        step();
        chk("wr_pulse_we_n", d, 32'(sram_we_n[d]), 32'd0);
        chk("wr_pulse_doe", d, 32'(sram_doe[d]), 32'd1);
      end
      step();
      chk("wr_hold_we_n", d, 32'(sram_we_n[d]), 32'd1);
      chk("wr_hold_doe", d, 32'(sram_doe[d]), 32'd1);
      chk("wr_hold_addr", d, 32'(sram_addr[d]), 32'(ad));
      chk("wr_hold_dout", d, 32'(sram_dout[d]), 32'(dat));
      step();
      chk("wr_end_doe", d, 32'(sram_doe[d]), 32'd0);
      chk("wr_no_rvalid", d, 32'(a_rvalid[d] | b_rvalid[d]), 32'd0);
      chk("wr_mem", d, 32'(mem_of(d, ad)), 32'(dat));
    end
  endtask

  typedef struct {
    bit         port;
    bit         we;
    bit         pre;
    logic [20:0] addr;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl [10];
  int   n_gnt, last_cyc;
  bit   exp_p;

  initial begin
    // port, we, preload, addr, data (read: expected rdata; write: wdata)
    tbl[0] = '{1'b0, 1'b0, 1'b1, 21'h01234,  8'h5A};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 21'h1FFFF,  8'hC3};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 21'h1FFFF,  8'hC3};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 21'h00010,  8'h11};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 21'h00011,  8'h22};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 21'h00012,  8'h33};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 21'h00013,  8'h44};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 21'h000000, 8'hA5};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 21'h1FFFFF, 8'h7E};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 21'h000000, 8'hA5};

    rst = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int d = 0; d < 2; d++) begin
      set_req(d, 1'b0, 1'b0, 1'b0, '0, '0);
      set_req(d, 1'b1, 1'b0, 1'b0, '0, '0);
      prev_we_n[d] = 1'b1; prev_addr[d] = '0; prev_dout[d] = '0;
    end
    step(); step();

    // Reset values.
    for (int d = 0; d < 2; d++) begin
      chk("rst_addr", d, 32'(sram_addr[d]), 32'd0);
      chk("rst_dout", d, 32'(sram_dout[d]), 32'd0);
      chk("rst_doe", d, 32'(sram_doe[d]), 32'd0);
      chk("rst_we_n", d, 32'(sram_we_n[d]), 32'd1);
      chk("rst_oe_n", d, 32'(sram_oe_n[d]), 32'd1);
      chk("rst_ack", d, 32'(a_ack[d] | b_ack[d]), 32'd0);
      chk("rst_rvalid", d, 32'(a_rvalid[d] | b_rvalid[d]), 32'd0);
      chk("rst_rdata", d, 32'({a_rdata[d], b_rdata[d]}), 32'd0);
    end

    // Preload read targets while still in reset.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].pre) begin
        pl_en = 1'b1; pl_addr = tbl[i].addr; pl_data = tbl[i].data;
        step();
      end
    end
    pl_en = 1'b0;
    rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++) chk("idle_oe_n", d, 32'(sram_oe_n[d]), 32'd0);

    // Table of single accesses, back to back, on both timing builds.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 10; i++) begin
        do_txn(d, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].data);
      end
    end

    // Reset during the write pulse drops the access and idles the bus.
    set_req(0, 1'b0, 1'b1, 1'b1, 21'h00555, 8'h66);
    step();
    chk("rstw_ack", 0, 32'(a_ack[0]), 32'd1);
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(); step();
    chk("rstw_pulse", 0, 32'(sram_we_n[0]), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_we_n", 0, 32'(sram_we_n[0]), 32'd1);
    chk("rstw_doe", 0, 32'(sram_doe[0]), 32'd0);
    chk("rstw_addr", 0, 32'(sram_addr[0]), 32'd0);
    chk("rstw_ack0", 0, 32'(a_ack[0] | b_ack[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstw_idle_doe", 0, 32'(sram_doe[0]), 32'd0);
      chk("rstw_idle_we_n", 0, 32'(sram_we_n[0]), 32'd1);
      chk("rstw_idle_oe_n", 0, 32'(sram_oe_n[0]), 32'd0);
      chk("rstw_idle_hs", 0, 32'({a_ack[0], b_ack[0], a_rvalid[0], b_rvalid[0]}), 32'd0);
    end

    // Both ports requesting continuously: grants alternate A,B,... every 3 cycles.
    set_req(0, 1'b0, 1'b1, 1'b0, 21'h01234, 8'h00);
    set_req(0, 1'b1, 1'b1, 1'b0, 21'h1FFFF, 8'h00);
    n_gnt = 0; exp_p = 1'b0; last_cyc = 0;
    for (int c = 1; c <= 60 && n_gnt < 8; c++) begin
      step();
      if (a_rvalid[0]) chk("alt_a_rdata", 0, 32'(a_rdata[0]), 32'h5A);
      if (b_rvalid[0]) chk("alt_b_rdata", 0, 32'(b_rdata[0]), 32'hC3);
      if (a_ack[0] || b_ack[0]) begin
        chk("alt_one_ack", 0, 32'(a_ack[0] & b_ack[0]), 32'd0);
        chk("alt_order", 0, 32'(b_ack[0]), 32'(exp_p));
        if (n_gnt > 0) chk("alt_spacing", 0, 32'(c - last_cyc), 32'd3);
        last_cyc = c;
        exp_p = ~exp_p;
        n_gnt++;
      end
    end
    chk("alt_count", 0, 32'(n_gnt), 32'd8);
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(0, 1'b1, 1'b0, 1'b0, '0, '0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
